// File: rtl/uart_pkg.sv
// Shared UART transmit types: FSM state encoding, idle line level and parity helper.
// Parity helper takes a zero-extended word so callers of any width up to 64 bits can share it.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LINE    = 1'b1;
  localparam int   PARITY_MAX_W = 64;

  function automatic logic parity_calc(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: tick is high in the last cycle of every CLKS_PER_BIT window.
// clear holds the count at zero so the first window after release is a full bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from a synchronous-read FIFO and shifts it out as a UART frame on tx.
// Minimum gap between frames is 3 idle-high cycles; tx_en only gates the start of new frames.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int            BW        = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic                  tx_q, tx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  tick;
  logic                  baud_clear;

  // Baud timer is held in the pre-frame states so START gets a full bit period.
  assign baud_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= IDLE_LINE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    par_d      = par_q;
    fifo_r_en  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        fifo_r_en = 1'b1;
        state_d   = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        par_d   = parity_calc(PARITY_MAX_W'(fifo_data), PARITY_ODD);
        bit_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (PARITY_EN) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = IDLE_LINE;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d    = IDLE_LINE;
          state_d = STOP;
        end
      end
      STOP: begin
        // bit_q counts completed stop bits here.
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = IDLE_LINE;
        state_d = IDLE;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three transmitters (plain, even parity, odd parity + 2 stops) each fed by a
// synchronous-read FIFO model; captured tx waveforms are compared cycle by cycle with expected frames.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b1;
  logic [2:0] tx_en_v = 3'b000;
  wire  [2:0] tx_v, busy_v, done_v, ren_v, empty_v;

  logic [7:0] mem [3][16];
  logic [7:0] fdata [3];
  int wp[3]    = '{0, 0, 0};
  int rp[3]    = '{0, 0, 0};
  int pops[3]  = '{0, 0, 0};
  int dones[3] = '{0, 0, 0};
  int bad_pops = 0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] wave;
    int          len;
  } exp_t;
  exp_t sb[$];

  assign empty_v = {wp[2] == rp[2], wp[1] == rp[1], wp[0] == rp[0]};

  // Synchronous-read FIFO models: data_out valid the cycle after a pop.
  always @(posedge clk) begin
    for (int w = 0; w < 3; w++) begin
      if (ren_v[w]) begin
        if (wp[w] != rp[w]) begin
          fdata[w] <= mem[w][rp[w] % 16];
          rp[w]    <= rp[w] + 1;
          pops[w]  <= pops[w] + 1;
        end else begin
          bad_pops <= bad_pops + 1;
        end
      end
      if (done_v[w]) dones[w] <= dones[w] + 1;
    end
  end

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                 .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en_v[0]), .fifo_empty(empty_v[0]),
    .fifo_data(fdata[0]), .fifo_r_en(ren_v[0]), .tx(tx_v[0]), .busy(busy_v[0]),
    .frame_done(done_v[0]));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                 .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en_v[1]), .fifo_empty(empty_v[1]),
    .fifo_data(fdata[1]), .fifo_r_en(ren_v[1]), .tx(tx_v[1]), .busy(busy_v[1]),
    .frame_done(done_v[1]));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
                 .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en_v[2]), .fifo_empty(empty_v[2]),
    .fifo_data(fdata[2]), .fifo_r_en(ren_v[2]), .tx(tx_v[2]), .busy(busy_v[2]),
    .frame_done(done_v[2]));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected per-cycle line level: start, data LSB first, optional parity, stop bits.
  function automatic exp_t build_frame(input logic [7:0] d, input int w);
    exp_t        e;
    logic [15:0] bits;
    int          nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (w != 0) begin
      bits[9] = (^d) ^ (w == 2);
      nb      = 10;
    end
    nb     = nb + ((w == 2) ? 2 : 1);
    e.wave = '1;
    e.len  = nb * CPB;
    for (int c = 0; c < e.len; c++) e.wave[c] = bits[c / CPB];
    return e;
  endfunction

  task automatic push_byte(input int w, input logic [7:0] d);
    mem[w][wp[w] % 16] = d;
    wp[w] = wp[w] + 1;
    sb.push_back(build_frame(d, w));
  endtask

  task automatic wait_fall(input int w);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = !tx_v[w];
    end
    check("fall_seen", 64'(seen), 64'd1);
  endtask

  // Records tx from the first low cycle through the frame_done cycle; gap counts prior high cycles.
  task automatic capture(input int w, output logic [63:0] wave, output int len, output int gap);
    bit seen = 1'b0;
    wave = '1;
    len  = 0;
    gap  = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (tx_v[w] == 1'b0) seen = 1'b1;
      else gap++;
    end
    check("start_seen", 64'(seen), 64'd1);
    if (seen) begin
      wave[0] = tx_v[w];
      len     = 1;
      while (!done_v[w] && len < 64) begin
        @(negedge clk);
        wave[len] = tx_v[w];
        len++;
      end
    end
  endtask

  task automatic check_frame(input int w, input string tag, output int gap);
    exp_t        e;
    logic [63:0] wv;
    int          len;
    capture(w, wv, len, gap);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.wave = '0;
      e.len  = 0;
    end
    check({tag, "_len"}, 64'(len), 64'(e.len));
    check({tag, "_wave"}, wv, e.wave);
  endtask

  initial begin
    int   gap;
    exp_t dropped;

    #1 rst_n = 1'b0;
    push_byte(0, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_outs", 64'({tx_v, busy_v, ren_v}), 64'h1C0);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_pop_txen0", 64'(pops[0]), 64'd0);
    check("idle_lines", 64'({tx_v, busy_v}), 64'h38);

    tx_en_v[0] = 1'b1;
    check_frame(0, "a5", gap);
    repeat (2) @(negedge clk);
    check("a5_pops", 64'(pops[0]), 64'd1);
    check("a5_done", 64'(dones[0]), 64'd1);

    push_byte(0, 8'h00);
    push_byte(0, 8'hFF);
    push_byte(0, 8'h3C);
    check_frame(0, "b2b_00", gap);
    check_frame(0, "b2b_ff", gap);
    check("gap_1", 64'(gap), 64'd3);
    check_frame(0, "b2b_3c", gap);
    check("gap_2", 64'(gap), 64'd3);
    repeat (5) @(negedge clk);
    check("b2b_pops", 64'(pops[0]), 64'd4);
    check("b2b_done", 64'(dones[0]), 64'd4);
    check("b2b_idle", 64'({busy_v[0], empty_v[0]}), 64'd1);

    push_byte(0, 8'h5A);
    push_byte(0, 8'hC3);
    fork
      check_frame(0, "hold_5a", gap);
      begin
        wait_fall(0);
        repeat (17) @(negedge clk);
        tx_en_v[0] = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("hold_pops", 64'(pops[0]), 64'd5);
    check("hold_busy", 64'(busy_v[0]), 64'd0);
    tx_en_v[0] = 1'b1;
    check_frame(0, "resume_c3", gap);

    push_byte(0, 8'h96);
    push_byte(0, 8'h69);
    wait_fall(0);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("arst_tx_busy", 64'({tx_v[0], busy_v[0]}), 64'd2);
    if (sb.size() > 0) dropped = sb.pop_front();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(0, "after_rst_69", gap);
    repeat (2) @(negedge clk);
    check("rst_pops", 64'(pops[0]), 64'd8);

    push_byte(1, 8'h07);
    tx_en_v[1] = 1'b1;
    check_frame(1, "par_even", gap);
    push_byte(2, 8'h07);
    tx_en_v[2] = 1'b1;
    check_frame(2, "par_odd_2stop", gap);
    repeat (3) @(negedge clk);
    check("par_pops", 64'({pops[2][7:0], pops[1][7:0]}), 64'h0101);
    check("bad_pops", 64'(bad_pops), 64'd0);
    check("all_idle", 64'({tx_v, busy_v}), 64'h38);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
